// File: rtl/alu_rs_sched_pkg.sv
// Shared types and sizing for the ALU reservation station.
// Optional feature macro: ALU_RS_FAST_WAKEUP_EN (see alu_rs_sched.sv).
package alu_rs_sched_pkg;

    localparam int unsigned RS_SIZE = 16;
    localparam int unsigned ROB_W   = 4;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned IDX_W   = $clog2(RS_SIZE);

    typedef enum logic [OP_W-1:0] {
        OpNop, OpLui, OpAuipc, OpJal, OpJalr,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
    } alu_op_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
        logic             r1;
        logic             r2;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [ROB_W-1:0] id;
    } rs_entry_t;

    typedef struct packed {
        logic             en;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  r1;
        logic [XLEN-1:0]  r2;
        logic [ROB_W-1:0] id;
    } issue_t;

    // Resolve one operand against both CDBs; returns {ready, value}. ALU bus has priority.
    function automatic logic [XLEN:0] snoop(
        input logic             r,
        input logic [ROB_W-1:0] q,
        input logic [XLEN-1:0]  v,
        input logic             a_en,
        input logic [ROB_W-1:0] a_id,
        input logic [XLEN-1:0]  a_data,
        input logic             l_en,
        input logic [ROB_W-1:0] l_id,
        input logic [XLEN-1:0]  l_data
    );
        if (r)                       return {1'b1, v};
        else if (a_en && a_id == q)  return {1'b1, a_data};
        else if (l_en && l_id == q)  return {1'b1, l_data};
        else                         return {1'b0, v};
    endfunction

endpackage

// File: rtl/alu_rs_sched_select.sv
// Find-first-set: lowest set bit of req_i reported as {valid_o, idx_o}.
module alu_rs_select #(
    parameter int unsigned N    = 16,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan downwards so the lowest requesting index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs_sched.sv
// ALU reservation station: dispatch, dual-CDB wakeup, lowest-index select, registered issue.
// Macro ALU_RS_FAST_WAKEUP_EN lets an operand woken by a same-cycle CDB be selected at once.
module alu_rs_sched
    import alu_rs_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             disp_en,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [XLEN-1:0]  disp_imm,
    input  logic [XLEN-1:0]  disp_pc,
    input  logic [ROB_W-1:0] disp_q1,
    input  logic [ROB_W-1:0] disp_q2,
    input  logic             disp_r1,
    input  logic             disp_r2,
    input  logic [XLEN-1:0]  disp_v1,
    input  logic [XLEN-1:0]  disp_v2,
    input  logic [ROB_W-1:0] disp_id,
    output logic             full_o,
    input  logic             cdbA_en,
    input  logic [ROB_W-1:0] cdbA_id,
    input  logic [XLEN-1:0]  cdbA_data,
    input  logic             cdbL_en,
    input  logic [ROB_W-1:0] cdbL_id,
    input  logic [XLEN-1:0]  cdbL_data,
    output logic             alu_en_o,
    output logic [OP_W-1:0]  alu_op_o,
    output logic [XLEN-1:0]  alu_imm_o,
    output logic [XLEN-1:0]  alu_pc_o,
    output logic [XLEN-1:0]  alu_r1_o,
    output logic [XLEN-1:0]  alu_r2_o,
    output logic [ROB_W-1:0] alu_id_o
);

    localparam logic [IDX_W:0] OneFree = 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];
    rs_entry_t          ent_s [RS_SIZE];
    issue_t             out_q, out_d;

    logic [RS_SIZE-1:0] free_req, ready_req;
    logic               free_valid, sel_valid;
    logic [IDX_W-1:0]   free_idx, sel_idx;
    logic [IDX_W:0]     free_cnt;

    // Entries as they look after this cycle's CDB broadcasts are applied.
    always_comb begin
        ent_s = ent_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            {ent_s[i].r1, ent_s[i].v1} = snoop(ent_q[i].r1, ent_q[i].q1, ent_q[i].v1,
                                               cdbA_en, cdbA_id, cdbA_data,
                                               cdbL_en, cdbL_id, cdbL_data);
            {ent_s[i].r2, ent_s[i].v2} = snoop(ent_q[i].r2, ent_q[i].q2, ent_q[i].v2,
                                               cdbA_en, cdbA_id, cdbA_data,
                                               cdbL_en, cdbL_id, cdbL_data);
        end
    end

    always_comb begin
        free_req = ~busy_q;
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_FAST_WAKEUP_EN
            ready_req[i] = busy_q[i] && ent_s[i].r1 && ent_s[i].r2;
`else
            ready_req[i] = busy_q[i] && ent_q[i].r1 && ent_q[i].r2;
`endif
        end
    end

    alu_rs_select #(
        .N    (RS_SIZE),
        .IdxW (IDX_W)
    ) u_free_sel (
        .req_i   (free_req),
        .valid_o (free_valid),
        .idx_o   (free_idx)
    );

    alu_rs_select #(
        .N    (RS_SIZE),
        .IdxW (IDX_W)
    ) u_ready_sel (
        .req_i   (ready_req),
        .valid_o (sel_valid),
        .idx_o   (sel_idx)
    );

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_cnt = free_cnt + {{IDX_W{1'b0}}, ~busy_q[i]};
        end
    end

    assign full_o = (free_cnt <= OneFree);

    always_comb begin
        busy_d = busy_q;
        ent_d  = ent_q;
        out_d  = out_q;
        if (rdy) begin
            out_d.en = 1'b0;
            if (clear) begin
                busy_d = '0;
            end else begin
                ent_d = ent_s;
                // Issue reads the snooped copy so fast wakeup forwards CDB data directly.
                if (sel_valid) begin
                    out_d.en  = 1'b1;
                    out_d.op  = ent_s[sel_idx].op;
                    out_d.imm = ent_s[sel_idx].imm;
                    out_d.pc  = ent_s[sel_idx].pc;
                    out_d.r1  = ent_s[sel_idx].v1;
                    out_d.r2  = ent_s[sel_idx].v2;
                    out_d.id  = ent_s[sel_idx].id;
                    busy_d[sel_idx] = 1'b0;
                end
                // free_idx comes from pre-edge busy, so it never aliases the issuing slot.
                if (disp_en && free_valid) begin
                    busy_d[free_idx]     = 1'b1;
                    ent_d[free_idx].op   = disp_op;
                    ent_d[free_idx].imm  = disp_imm;
                    ent_d[free_idx].pc   = disp_pc;
                    ent_d[free_idx].q1   = disp_q1;
                    ent_d[free_idx].q2   = disp_q2;
                    ent_d[free_idx].id   = disp_id;
                    {ent_d[free_idx].r1, ent_d[free_idx].v1} =
                        snoop(disp_r1, disp_q1, disp_v1, cdbA_en, cdbA_id, cdbA_data,
                              cdbL_en, cdbL_id, cdbL_data);
                    {ent_d[free_idx].r2, ent_d[free_idx].v2} =
                        snoop(disp_r2, disp_q2, disp_v2, cdbA_en, cdbA_id, cdbA_data,
                              cdbL_en, cdbL_id, cdbL_data);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            out_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            out_q  <= out_d;
            ent_q  <= ent_d;
        end
    end

    assign alu_en_o  = out_q.en;
    assign alu_op_o  = out_q.op;
    assign alu_imm_o = out_q.imm;
    assign alu_pc_o  = out_q.pc;
    assign alu_r1_o  = out_q.r1;
    assign alu_r2_o  = out_q.r2;
    assign alu_id_o  = out_q.id;

    // Dispatch into a station with no free entry is a protocol violation by the dispatcher.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (rdy && disp_en && !clear) |-> free_valid);

endmodule

// File: tb/tb_alu_rs_sched.sv
// Self-checking bench for alu_rs_sched: directed scenarios plus random traffic vs. a model.
module tb_alu_rs_sched;
    import alu_rs_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst, rdy, clear, disp_en;
    logic [OP_W-1:0]  disp_op;
    logic [XLEN-1:0]  disp_imm, disp_pc, disp_v1, disp_v2;
    logic [ROB_W-1:0] disp_q1, disp_q2, disp_id;
    logic             disp_r1, disp_r2;
    logic             full_o;
    logic             cdbA_en, cdbL_en;
    logic [ROB_W-1:0] cdbA_id, cdbL_id;
    logic [XLEN-1:0]  cdbA_data, cdbL_data;
    logic             alu_en_o;
    logic [OP_W-1:0]  alu_op_o;
    logic [XLEN-1:0]  alu_imm_o, alu_pc_o, alu_r1_o, alu_r2_o;
    logic [ROB_W-1:0] alu_id_o;

    int checks = 0;
    int errors = 0;

    alu_rs_sched dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .disp_en(disp_en), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_r1(disp_r1), .disp_r2(disp_r2),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_id(disp_id), .full_o(full_o),
        .cdbA_en(cdbA_en), .cdbA_id(cdbA_id), .cdbA_data(cdbA_data),
        .cdbL_en(cdbL_en), .cdbL_id(cdbL_id), .cdbL_data(cdbL_data),
        .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o),
        .alu_r1_o(alu_r1_o), .alu_r2_o(alu_r2_o), .alu_id_o(alu_id_o)
    );

    always #5 clk = ~clk;

    // Reference model: a table of waiting ops plus the last issued op.
    logic             m_busy [RS_SIZE];
    logic [OP_W-1:0]  m_op   [RS_SIZE];
    logic [XLEN-1:0]  m_imm  [RS_SIZE];
    logic [XLEN-1:0]  m_pc   [RS_SIZE];
    logic [ROB_W-1:0] m_q1   [RS_SIZE];
    logic [ROB_W-1:0] m_q2   [RS_SIZE];
    logic             m_r1   [RS_SIZE];
    logic             m_r2   [RS_SIZE];
    logic [XLEN-1:0]  m_v1   [RS_SIZE];
    logic [XLEN-1:0]  m_v2   [RS_SIZE];
    logic [ROB_W-1:0] m_id   [RS_SIZE];
    logic             exp_en;
    logic [OP_W-1:0]  exp_op;
    logic [XLEN-1:0]  exp_imm, exp_pc, exp_v1, exp_v2;
    logic [ROB_W-1:0] exp_id;

    function automatic logic on_cdb(input logic [ROB_W-1:0] tag);
        return (cdbA_en && cdbA_id == tag) || (cdbL_en && cdbL_id == tag);
    endfunction

    function automatic logic [XLEN-1:0] cdb_val(input logic [ROB_W-1:0] tag);
        return (cdbA_en && cdbA_id == tag) ? cdbA_data : cdbL_data;
    endfunction

    function automatic logic usable(input logic r, input logic [ROB_W-1:0] q);
`ifdef ALU_RS_FAST_WAKEUP_EN
        return r || on_cdb(q);
`else
        return r;
`endif
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic model_full();
        return model_free() <= 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
        exp_en = 1'b0; exp_op = '0; exp_imm = '0; exp_pc = '0;
        exp_v1 = '0; exp_v2 = '0; exp_id = '0;
    endtask

    task automatic model_step();
        int pick = -1;
        int slot = -1;
        if (!rdy) return;
        if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
            exp_en = 1'b0;
            return;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (slot < 0 && !m_busy[i]) slot = i;
            if (pick < 0 && m_busy[i] && usable(m_r1[i], m_q1[i]) && usable(m_r2[i], m_q2[i]))
                pick = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m_busy[i] && !m_r1[i] && on_cdb(m_q1[i])) begin
                m_r1[i] = 1'b1; m_v1[i] = cdb_val(m_q1[i]);
            end
            if (m_busy[i] && !m_r2[i] && on_cdb(m_q2[i])) begin
                m_r2[i] = 1'b1; m_v2[i] = cdb_val(m_q2[i]);
            end
        end
        exp_en = (pick >= 0);
        if (pick >= 0) begin
            exp_op = m_op[pick]; exp_imm = m_imm[pick]; exp_pc = m_pc[pick];
            exp_v1 = m_v1[pick]; exp_v2 = m_v2[pick]; exp_id = m_id[pick];
            m_busy[pick] = 1'b0;
        end
        if (disp_en && slot >= 0) begin
            m_busy[slot] = 1'b1;
            m_op[slot] = disp_op; m_imm[slot] = disp_imm; m_pc[slot] = disp_pc;
            m_q1[slot] = disp_q1; m_q2[slot] = disp_q2; m_id[slot] = disp_id;
            m_r1[slot] = disp_r1 || on_cdb(disp_q1);
            m_v1[slot] = (!disp_r1 && on_cdb(disp_q1)) ? cdb_val(disp_q1) : disp_v1;
            m_r2[slot] = disp_r2 || on_cdb(disp_q2);
            m_v2[slot] = (!disp_r2 && on_cdb(disp_q2)) ? cdb_val(disp_q2) : disp_v2;
        end
    endtask

    task automatic idle();
        rdy = 1'b1; clear = 1'b0; disp_en = 1'b0; cdbA_en = 1'b0; cdbL_en = 1'b0;
        disp_op = '0; disp_imm = '0; disp_pc = '0; disp_q1 = '0; disp_q2 = '0;
        disp_r1 = 1'b0; disp_r2 = 1'b0; disp_v1 = '0; disp_v2 = '0; disp_id = '0;
        cdbA_id = '0; cdbA_data = '0; cdbL_id = '0; cdbL_data = '0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [XLEN-1:0] imm,
                            input logic [ROB_W-1:0] q1, input logic r1, input logic [XLEN-1:0] v1,
                            input logic [ROB_W-1:0] q2, input logic r2, input logic [XLEN-1:0] v2,
                            input logic [ROB_W-1:0] id);
        disp_en = 1'b1; disp_op = op; disp_imm = imm; disp_pc = 32'h1000 | XLEN'(id);
        disp_q1 = q1; disp_r1 = r1; disp_v1 = v1;
        disp_q2 = q2; disp_r2 = r2; disp_v2 = v2; disp_id = id;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (alu_en_o !== 1'b0 || full_o !== 1'b0) begin
            errors++; $display("FAIL reset_state: en=%b full=%b want 0 0", alu_en_o, full_o);
        end
        checks++;
        if ({alu_op_o, alu_imm_o, alu_pc_o, alu_r1_o, alu_r2_o, alu_id_o} !== '0) begin
            errors++; $display("FAIL reset_payload: r1=%h id=%h want 0", alu_r1_o, alu_id_o);
        end
        set_disp(OpAddi, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 4'd5);
        tick();
        set_disp(OpAddi, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 1'b1, 32'd0, 4'd6);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (alu_en_o !== 1'b0 || full_o !== 1'b0) begin
            errors++; $display("FAIL reset_async: en=%b full=%b want 0 0", alu_en_o, full_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (alu_en_o !== 1'b0) begin
                errors++; $display("FAIL reset_no_issue: cycle %0d en=%b want 0", i, alu_en_o);
            end
        end
    endtask

    task automatic test_addi();
        set_disp(OpAddi, 32'd3, 4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd2);
        tick();
        idle();
        tick();
        checks++;
        if ({alu_en_o, alu_r1_o, alu_imm_o, alu_id_o, alu_op_o} !==
            {1'b1, 32'd5, 32'd3, 4'd2, OP_W'(OpAddi)}) begin
            errors++;
            $display("FAIL addi_issue: en=%b r1=%0d imm=%0d id=%0d op=%0d want 1 5 3 2 %0d",
                     alu_en_o, alu_r1_o, alu_imm_o, alu_id_o, alu_op_o, OpAddi);
        end
        tick();
        checks++;
        if (alu_en_o !== 1'b0 || alu_id_o !== 4'd2) begin
            errors++; $display("FAIL addi_hold: en=%b id=%0d want 0 2", alu_en_o, alu_id_o);
        end
    endtask

    task automatic test_cdb_wakeup();
        set_disp(OpAdd, 32'd0, 4'd7, 1'b0, 32'd0, 4'd0, 1'b1, 32'd9, 4'd3);
        tick();
        idle();
        tick();
        checks++;
        if (alu_en_o !== 1'b0) begin
            errors++; $display("FAIL wake_wait: en=%b want 0", alu_en_o);
        end
        cdbL_en = 1'b1; cdbL_id = 4'd7; cdbL_data = 32'h10;
        tick();
        idle();
`ifndef ALU_RS_FAST_WAKEUP_EN
        checks++;
        if (alu_en_o !== 1'b0) begin
            errors++; $display("FAIL wake_slow_gap: en=%b want 0", alu_en_o);
        end
        tick();
`endif
        checks++;
        if ({alu_en_o, alu_r1_o, alu_r2_o, alu_id_o} !== {1'b1, 32'h10, 32'd9, 4'd3}) begin
            errors++; $display("FAIL wake_issue: en=%b r1=%h r2=%h id=%0d want 1 10 9 3",
                               alu_en_o, alu_r1_o, alu_r2_o, alu_id_o);
        end
        set_disp(OpAdd, 32'd0, 4'd7, 1'b0, 32'd0, 4'd5, 1'b1, 32'd1, 4'd4);
        cdbA_en = 1'b1; cdbA_id = 4'd7; cdbA_data = 32'h22;
        tick();
        idle();
        tick();
        checks++;
        if ({alu_en_o, alu_r1_o, alu_id_o} !== {1'b1, 32'h22, 4'd4}) begin
            errors++; $display("FAIL disp_collide: en=%b r1=%h id=%0d want 1 22 4",
                               alu_en_o, alu_r1_o, alu_id_o);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 15; i++) begin
            set_disp(OpAdd, 32'd0, ROB_W'(i), 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, ROB_W'(i));
            tick();
            checks++;
            if (full_o !== (i + 1 >= 15)) begin
                errors++; $display("FAIL full_fill: occ=%0d full=%b want %b", i + 1, full_o, i + 1 >= 15);
            end
        end
        idle();
        cdbA_en = 1'b1; cdbA_id = 4'd3; cdbA_data = 32'h33;
        tick();
        idle();
`ifndef ALU_RS_FAST_WAKEUP_EN
        checks++;
        if (full_o !== 1'b1 || alu_en_o !== 1'b0) begin
            errors++; $display("FAIL full_slow_gap: full=%b en=%b want 1 0", full_o, alu_en_o);
        end
        tick();
`endif
        checks++;
        if ({alu_en_o, alu_id_o, alu_r1_o, full_o} !== {1'b1, 4'd3, 32'h33, 1'b0}) begin
            errors++; $display("FAIL full_drain: en=%b id=%0d r1=%h full=%b want 1 3 33 0",
                               alu_en_o, alu_id_o, alu_r1_o, full_o);
        end
        clear = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) begin
            set_disp(OpSub, 32'd0, ROB_W'(8 + i), 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, ROB_W'(8 + i));
            tick();
        end
        idle();
        cdbA_en = 1'b1; cdbA_id = 4'd9;  cdbA_data = 32'h91;
        cdbL_en = 1'b1; cdbL_id = 4'd12; cdbL_data = 32'hC4;
        tick();
        idle();
`ifndef ALU_RS_FAST_WAKEUP_EN
        tick();
`endif
        checks++;
        if ({alu_en_o, alu_id_o, alu_r1_o} !== {1'b1, 4'd9, 32'h91}) begin
            errors++; $display("FAIL prio_first: en=%b id=%0d r1=%h want 1 9 91",
                               alu_en_o, alu_id_o, alu_r1_o);
        end
        tick();
        checks++;
        if ({alu_en_o, alu_id_o, alu_r1_o} !== {1'b1, 4'd12, 32'hC4}) begin
            errors++; $display("FAIL prio_second: en=%b id=%0d r1=%h want 1 12 c4",
                               alu_en_o, alu_id_o, alu_r1_o);
        end
        clear = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_clear_freeze();
        for (int i = 0; i < 8; i++) begin
            set_disp(OpXor, 32'd0, ROB_W'(i), 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, ROB_W'(i));
            tick();
        end
        set_disp(OpAddi, 32'd0, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 32'd0, 4'd15);
        clear = 1'b1;
        tick();
        idle();
        checks++;
        if (alu_en_o !== 1'b0 || full_o !== 1'b0) begin
            errors++; $display("FAIL clear_state: en=%b full=%b want 0 0", alu_en_o, full_o);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                cdbA_en = 1'b1; cdbA_id = ROB_W'(i); cdbA_data = 32'h55;
            end
            tick();
            idle();
            checks++;
            if (alu_en_o !== 1'b0) begin
                errors++; $display("FAIL clear_no_issue: step %0d en=%b want 0", i, alu_en_o);
            end
        end
        set_disp(OpOr, 32'd0, 4'd0, 1'b1, 32'hA, 4'd0, 1'b1, 32'd0, 4'd1);
        tick();
        set_disp(OpOr, 32'd0, 4'd0, 1'b1, 32'hB, 4'd0, 1'b1, 32'd0, 4'd2);
        tick();
        set_disp(OpAnd, 32'd0, 4'd0, 1'b1, 32'hC, 4'd0, 1'b1, 32'd0, 4'd3);
        rdy = 1'b0; clear = 1'b1;
        cdbA_en = 1'b1; cdbA_id = 4'd2; cdbA_data = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({alu_en_o, alu_id_o, alu_r1_o, full_o} !== {1'b1, 4'd1, 32'hA, model_full()}) begin
                errors++; $display("FAIL freeze: cycle %0d en=%b id=%0d r1=%h full=%b want 1 1 a %b",
                                   i, alu_en_o, alu_id_o, alu_r1_o, full_o, model_full());
            end
        end
        idle();
        tick();
        checks++;
        if ({alu_en_o, alu_id_o, alu_r1_o} !== {1'b1, 4'd2, 32'hB}) begin
            errors++; $display("FAIL thaw_issue: en=%b id=%0d r1=%h want 1 2 b",
                               alu_en_o, alu_id_o, alu_r1_o);
        end
        tick();
        checks++;
        if (alu_en_o !== 1'b0) begin
            errors++; $display("FAIL thaw_empty: en=%b want 0", alu_en_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy   = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1 && model_free() > 0) begin
                set_disp(OP_W'($urandom_range(0, 29)), $urandom,
                         ROB_W'($urandom), $urandom_range(0, 2) == 0, $urandom,
                         ROB_W'($urandom), $urandom_range(0, 1) == 0, $urandom,
                         ROB_W'($urandom));
            end
            cdbA_en = ($urandom_range(0, 1) == 1);
            cdbA_id = ROB_W'($urandom); cdbA_data = $urandom;
            cdbL_en = ($urandom_range(0, 1) == 1);
            cdbL_id = cdbA_id ^ ROB_W'($urandom_range(1, 15)); cdbL_data = $urandom;
            tick();
            checks++;
            if ({alu_en_o, alu_op_o, alu_imm_o, alu_pc_o, alu_r1_o, alu_r2_o, alu_id_o, full_o} !==
                {exp_en, exp_op, exp_imm, exp_pc, exp_v1, exp_v2, exp_id, model_full()}) begin
                errors++;
                $display("FAIL random c=%0d: got en=%b op=%0d imm=%h pc=%h r1=%h r2=%h id=%0d full=%b want en=%b op=%0d imm=%h pc=%h r1=%h r2=%h id=%0d full=%b",
                         c, alu_en_o, alu_op_o, alu_imm_o, alu_pc_o, alu_r1_o, alu_r2_o, alu_id_o,
                         full_o, exp_en, exp_op, exp_imm, exp_pc, exp_v1, exp_v2, exp_id,
                         model_full());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_cdb_wakeup();
        test_full();
        test_priority();
        test_clear_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
